alu_seq: RTL and testbench

- Command-side sequencer that drives the team's 4-bit combinational ALU.
- Inputs to that ALU: a, b, 3-bit select. Outputs from it: result, c, z, overflow.
- Accepts operation commands over a valid/ready handshake and drives the ALU operands from registers.
- Waits a fixed settle time, then captures result and flags into a held response with its own valid/ready handshake.
- Keeps an accumulator so operations can be chained; sits between the nvboard/test front-end and the ALU.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_seq.sv | 106 ++++++++++
 tb/tb_alu_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: op codes, FSM states and default widths.
package alu_pkg;

    localparam int ALU_WIDTH = 4;
    localparam int ALU_OP_W  = 3;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_EQ  = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_seq.sv
// Command/response sequencer for the external 4-bit combinational ALU with a chaining accumulator.
// Optional ALU_SEQ_ZFIX_EN: derive the response zero flag locally from the captured result.
//
// state  | meaning
// IDLE   | ready for a command, ALU operands hold the previous command
// SETTLE | operands driven, settle down-counter running toward capture
// RESP   | response held until the consumer takes it
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH         = ALU_WIDTH,
    parameter int OP_W          = ALU_OP_W,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_select,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_c,
    input  logic             alu_z,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_c,
    output logic             rsp_z,
    output logic             rsp_ov,
    output logic [WIDTH-1:0] acc,
    output logic             busy
);

    seq_state_t state, state_next;
    logic [3:0] settle_cnt;
    logic       cap_z;
    logic       accept;
    logic       capture;

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign capture   = (state == SETTLE) && (settle_cnt == 4'd0);

`ifdef ALU_SEQ_ZFIX_EN
    assign cap_z = (alu_result == '0);
`else
    assign cap_z = alu_z;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SETTLE;
            SETTLE:  if (capture) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands stay registered after the response so the ALU inputs never glitch between commands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_select <= '0;
            settle_cnt <= 4'd0;
        end else if (accept) begin
            alu_a      <= cmd_use_acc ? acc : cmd_a;
            alu_b      <= cmd_b;
            alu_select <= cmd_op;
            settle_cnt <= 4'(SETTLE_CYCLES - 1);
        end else if (state == SETTLE && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_c      <= 1'b0;
            rsp_z      <= 1'b0;
            rsp_ov     <= 1'b0;
            acc        <= '0;
        end else if (capture) begin
            rsp_result <= alu_result;
            rsp_c      <= alu_c;
            rsp_z      <= cap_z;
            rsp_ov     <= alu_overflow;
            acc        <= alu_result;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: two instances (settle 1 and 3), each driven by a behavioural ALU.
module tb_alu_seq;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, rst3_n;
    int         total = 0;
    int         bad   = 0;

    logic       cmd_valid, cmd_use_acc, rsp_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a, cmd_b;
    logic       cmd_ready, rsp_valid, rsp_c, rsp_z, rsp_ov, busy;
    logic [3:0] alu_a, alu_b, rsp_result, acc;
    logic [2:0] alu_select;
    logic [3:0] alu_result;
    logic       alu_c, alu_z, alu_overflow;

    logic       d3_cmd_valid, d3_cmd_use_acc, d3_rsp_ready;
    logic [2:0] d3_cmd_op;
    logic [3:0] d3_cmd_a, d3_cmd_b;
    logic       d3_cmd_ready, d3_rsp_valid, d3_rsp_c, d3_rsp_z, d3_rsp_ov, d3_busy;
    logic [3:0] d3_alu_a, d3_alu_b, d3_rsp_result, d3_acc;
    logic [2:0] d3_alu_select;
    logic [3:0] d3_alu_result;
    logic       d3_alu_c, d3_alu_z, d3_alu_overflow;

    always #5 clk = ~clk;

    // Behavioural model of the external ALU, packed as {ov, z, c, result}.
    function automatic logic [6:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
        logic [4:0] s;
        logic [3:0] r;
        logic       c, v, z;
        c = 1'b0; v = 1'b0; z = 1'b0; s = 5'd0;
        case (sel)
            ALU_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[3:0]; c = s[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
                z = (r == 4'd0);
            end
            ALU_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 5'd1;
                r = s[3:0]; c = s[4];
                v = (a[3] != b[3]) && (r[3] != a[3]);
                z = (r == 4'd0);
            end
            ALU_NOT: r = ~a;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLT: r = {3'b000, $signed(a) < $signed(b)};
            default: r = {3'b000, a == b};
        endcase
        return {v, z, c, r};
    endfunction

    always_comb {alu_overflow, alu_z, alu_c, alu_result} = alu_f(alu_a, alu_b, alu_select);
    always_comb {d3_alu_overflow, d3_alu_z, d3_alu_c, d3_alu_result} = alu_f(d3_alu_a, d3_alu_b, d3_alu_select);

    alu_seq #(.WIDTH(4), .OP_W(3), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
        .alu_result(alu_result), .alu_c(alu_c), .alu_z(alu_z), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_ov(rsp_ov), .acc(acc), .busy(busy)
    );

    alu_seq #(.WIDTH(4), .OP_W(3), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst3_n),
        .cmd_valid(d3_cmd_valid), .cmd_ready(d3_cmd_ready), .cmd_op(d3_cmd_op),
        .cmd_a(d3_cmd_a), .cmd_b(d3_cmd_b), .cmd_use_acc(d3_cmd_use_acc),
        .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_select(d3_alu_select),
        .alu_result(d3_alu_result), .alu_c(d3_alu_c), .alu_z(d3_alu_z), .alu_overflow(d3_alu_overflow),
        .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_result(d3_rsp_result),
        .rsp_c(d3_rsp_c), .rsp_z(d3_rsp_z), .rsp_ov(d3_rsp_ov), .acc(d3_acc), .busy(d3_busy)
    );

    // Offer a command on the settle-1 instance, return the ALU operand seen after accept and the edges to rsp_valid.
    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic use_acc, output logic [3:0] seen_a, output int lat);
        @(negedge clk);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_use_acc = 1'b0;
        seen_a = alu_a;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if ({alu_a, alu_b, alu_select} !== 11'd0) begin bad++; $display("FAIL reset_alu_regs got=%h want=0", {alu_a, alu_b, alu_select}); end
        total++; if ({rsp_result, rsp_c, rsp_z, rsp_ov, acc} !== 11'd0) begin bad++; $display("FAIL reset_rsp_acc got=%h want=0", {rsp_result, rsp_c, rsp_z, rsp_ov, acc}); end
    endtask

    task automatic test_add();
        logic [3:0] sa; int lat;
        issue(ALU_ADD, 4'd7, 4'd1, 1'b0, sa, lat);
        total++; if (lat != 1) begin bad++; $display("FAIL add_latency got=%0d want=1", lat); end
        total++; if ({rsp_result, rsp_c, rsp_z, rsp_ov} !== {4'd8, 1'b0, 1'b0, 1'b1}) begin bad++;
            $display("FAIL add_rsp got=%h c%b z%b v%b want=8 c0 z0 v1", rsp_result, rsp_c, rsp_z, rsp_ov); end
        total++; if (acc !== 4'd8) begin bad++; $display("FAIL add_acc got=%h want=8", acc); end
        take_rsp();
        total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++;
            $display("FAIL add_handshake got ready=%b valid=%b want 1/0", cmd_ready, rsp_valid); end
    endtask

    task automatic test_sub();
        logic [3:0] sa; int lat;
        issue(ALU_SUB, 4'd3, 4'd3, 1'b0, sa, lat);
        total++; if (lat != 1 || {rsp_result, rsp_c, rsp_z, rsp_ov} !== {4'd0, 1'b1, 1'b1, 1'b0}) begin bad++;
            $display("FAIL sub_rsp got=%h c%b z%b v%b lat=%0d want=0 c1 z1 v0 lat=1", rsp_result, rsp_c, rsp_z, rsp_ov, lat); end
        take_rsp();
    endtask

    task automatic test_chain();
        logic [3:0] sa; int lat;
        issue(ALU_ADD, 4'd5, 4'd4, 1'b0, sa, lat);
        total++; if (rsp_result !== 4'd9 || acc !== 4'd9) begin bad++;
            $display("FAIL chain_first got=%h acc=%h want=9", rsp_result, acc); end
        take_rsp();
        issue(ALU_XOR, 4'd0, 4'hF, 1'b1, sa, lat);
        total++; if (sa !== 4'd9) begin bad++; $display("FAIL chain_alu_a got=%h want=9", sa); end
        total++; if (rsp_result !== 4'd6 || acc !== 4'd6 || rsp_c !== 1'b0 || rsp_ov !== 1'b0) begin bad++;
            $display("FAIL chain_xor got=%h acc=%h c%b v%b want=6 acc=6 c0 v0", rsp_result, acc, rsp_c, rsp_ov); end
        take_rsp();
    endtask

    task automatic test_backpressure();
        logic [3:0] sa; int lat; int unstable;
        issue(ALU_ADD, 4'd2, 4'd3, 1'b0, sa, lat);
        cmd_op = ALU_OR; cmd_a = 4'hC; cmd_b = 4'h3; cmd_valid = 1'b1;
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_result !== 4'd5 || alu_a !== 4'd2) unstable++;
        end
        total++; if (unstable != 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles want=0", unstable); end
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
        total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_a !== 4'd2 || alu_select !== ALU_ADD) begin bad++;
            $display("FAIL bp_release got ready=%b valid=%b alu_a=%h sel=%0d want 1/0/2/0", cmd_ready, rsp_valid, alu_a, alu_select); end
        cmd_valid = 1'b0;
    endtask

    task automatic test_and_zero();
        logic [3:0] sa; int lat; logic want_z;
`ifdef ALU_SEQ_ZFIX_EN
        want_z = 1'b1;
`else
        want_z = 1'b0;
`endif
        issue(ALU_AND, 4'hA, 4'h5, 1'b0, sa, lat);
        total++; if (rsp_result !== 4'd0 || rsp_z !== want_z) begin bad++;
            $display("FAIL and_zero got=%h z%b want=0 z%b", rsp_result, rsp_z, want_z); end
        take_rsp();
    endtask

    task automatic test_settle3_reset();
        int lat; int seen;
        @(negedge clk);
        d3_cmd_op = ALU_ADD; d3_cmd_a = 4'd1; d3_cmd_b = 4'd2; d3_cmd_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        d3_cmd_valid = 1'b0;
        lat = 0;
        while (!d3_rsp_valid && lat < 20) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        total++; if (lat != 3 || d3_rsp_result !== 4'd3 || d3_acc !== 4'd3) begin bad++;
            $display("FAIL s3_latency got lat=%0d res=%h acc=%h want 3/3/3", lat, d3_rsp_result, d3_acc); end
        d3_rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        d3_rsp_ready = 1'b0;
        d3_cmd_a = 4'd4; d3_cmd_b = 4'd4; d3_cmd_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        d3_cmd_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst3_n = 1'b0;
        #2;
        total++; if (d3_acc !== 4'd0 || d3_busy !== 1'b0 || d3_alu_a !== 4'd0) begin bad++;
            $display("FAIL s3_async_reset got acc=%h busy=%b alu_a=%h want 0/0/0", d3_acc, d3_busy, d3_alu_a); end
        @(negedge clk);
        rst3_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); @(negedge clk);
            if (d3_rsp_valid !== 1'b0) seen++;
        end
        total++; if (seen != 0 || d3_cmd_ready !== 1'b1 || d3_acc !== 4'd0) begin bad++;
            $display("FAIL s3_after_reset got valid_cycles=%0d ready=%b acc=%h want 0/1/0", seen, d3_cmd_ready, d3_acc); end
    endtask

    initial begin
        rst_n = 1'b0; rst3_n = 1'b0;
        cmd_valid = 1'b0; cmd_use_acc = 1'b0; rsp_ready = 1'b0;
        cmd_op = 3'd0; cmd_a = 4'd0; cmd_b = 4'd0;
        d3_cmd_valid = 1'b0; d3_cmd_use_acc = 1'b0; d3_rsp_ready = 1'b0;
        d3_cmd_op = 3'd0; d3_cmd_a = 4'd0; d3_cmd_b = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; rst3_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_chain();
        test_backpressure();
        test_and_zero();
        test_settle3_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
